// File: rtl/irq_gateway.sv
// irq_gateway: level/edge interrupt gateway with priority arbitration and claim/complete handshake to one hart
//   Ports: clk_i, rst_i (sync, active-high); src_i raw requests; le_i edge mode; ie_i enables;
//   prio_i per-source priority; threshold_i delivery threshold; claim_i, complete_i, complete_id_i hart handshake;
//   claim_id_o best deliverable ID (0 = none); irq_o = claim_id_o != 0; pending_o per-source PENDING flag.
//   Define IRQ_GATEWAY_EDGE_EN to enable per-source edge mode (src_q/held registers); otherwise all sources are level.
module irq_gateway #(
  parameter int NSRC = 4,
  parameter int PRIOW = 2,
  localparam int IDW = $clog2(NSRC + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NSRC-1:0]       src_i,
  input  logic [NSRC-1:0]       le_i,
  input  logic [NSRC-1:0]       ie_i,
  input  logic [NSRC*PRIOW-1:0] prio_i,
  input  logic [PRIOW-1:0]      threshold_i,
  input  logic                  claim_i,
  input  logic                  complete_i,
  input  logic [IDW-1:0]        complete_id_i,
  output logic [IDW-1:0]        claim_id_o,
  output logic                  irq_o,
  output logic [NSRC-1:0]       pending_o
);
  typedef enum logic [1:0] {IDLE, PEND, INSV} st_e;
  st_e st_q [NSRC];
  st_e st_d [NSRC];
  logic [IDW-1:0] claim_id_q, claim_id_d, best_id;
  logic [PRIOW-1:0] best_p, p;
  logic irq_q;
  logic [NSRC-1:0] req, hold, claim_hit, cmpl_hit;
`ifdef IRQ_GATEWAY_EDGE_EN
  logic [NSRC-1:0] src_q, held_q, held_d;
  // edge-mode sources request only on a rising edge
  assign req = src_i & ~(le_i & src_q);
  assign hold = held_q;
  always_comb begin
    for (int i = 0; i < NSRC; i++)
      held_d[i] = (st_q[i] == INSV && cmpl_hit[i]) ? 1'b0 :
                  (le_i[i] && req[i] && st_q[i] != IDLE) ? 1'b1 : held_q[i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q <= '0;
      held_q <= '0;
    end else begin
      src_q <= src_i;
      held_q <= held_d;
    end
  end
`else
  logic unused_le;
  assign unused_le = ^le_i;
  assign req = src_i;
  assign hold = '0;
`endif
  always_comb begin
    best_id = '0;
    best_p = '0;
    p = '0;
    // ascending scan with strict compare keeps the lowest ID on ties
    for (int i = 0; i < NSRC; i++) begin
      p = prio_i[i*PRIOW +: PRIOW];
      if (st_q[i] == PEND && ie_i[i] && p > threshold_i && p > best_p) begin
        best_p = p;
        best_id = IDW'(i + 1);
      end
    end
  end
  // a successful claim blanks the output for one cycle so the same ID cannot be claimed twice
  assign claim_id_d = (claim_i && claim_id_q != '0) ? '0 : best_id;
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      claim_hit[i] = claim_i && claim_id_q == IDW'(i + 1);
      cmpl_hit[i] = complete_i && complete_id_i == IDW'(i + 1);
      st_d[i] = (st_q[i] == IDLE && req[i]) ? PEND :
                (st_q[i] == PEND && claim_hit[i]) ? INSV :
                (st_q[i] == INSV && cmpl_hit[i]) ? (hold[i] ? PEND : IDLE) : st_q[i];
      pending_o[i] = st_q[i] == PEND;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSRC; i++) st_q[i] <= IDLE;
      claim_id_q <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) st_q[i] <= st_d[i];
      claim_id_q <= claim_id_d;
      irq_q <= claim_id_d != '0;
    end
  end
  assign claim_id_o = claim_id_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_irq_gateway.sv
// tb_irq_gateway: scoreboard bench for irq_gateway
module tb_irq_gateway;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] src = '0, le = '0, ie = 4'hF, pend;
  logic [7:0] prio = 8'hFE;
  logic [1:0] thr = 2'd1;
  logic claim = 1'b0, cmpl = 1'b0, irq;
  logic [2:0] cid = '0, claim_id;
  int n_run = 0, n_fail = 0;
  typedef struct {string tag; logic [3:0] pend; logic [2:0] id;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  irq_gateway dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .ie_i(ie), .prio_i(prio),
    .threshold_i(thr), .claim_i(claim), .complete_i(cmpl), .complete_id_i(cid),
    .claim_id_o(claim_id), .irq_o(irq), .pending_o(pend)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] s, input logic c, input logic m,
                     input logic [2:0] k, input logic [3:0] ep, input logic [2:0] eid);
    exp_t e;
    src = s; claim = c; cmpl = m; cid = k;
    sb.push_back('{tag, ep, eid});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, " pend"}, 32'(pend), 32'(e.pend));
    chk({e.tag, " id"}, 32'(claim_id), 32'(e.id));
    chk({e.tag, " irq"}, 32'(irq), 32'(e.id != 3'd0));
  endtask
  initial begin
    cyc("reset", 4'b0000, 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;
    // level request on source 2, claim, complete with level still high
    cyc("lvl_pend", 4'b0010, 0, 0, 0, 4'b0010, 0);
    cyc("lvl_irq", 4'b0010, 0, 0, 0, 4'b0010, 2);
    cyc("lvl_claim", 4'b0010, 1, 0, 0, 4'b0000, 0);
    cyc("lvl_insv", 4'b0010, 0, 0, 0, 4'b0000, 0);
    cyc("lvl_cmpl", 4'b0010, 0, 1, 2, 4'b0000, 0);
    cyc("lvl_repend", 4'b0010, 0, 0, 0, 4'b0010, 0);
    cyc("lvl_reirq", 4'b0010, 0, 0, 0, 4'b0010, 2);
    cyc("lvl_claim2", 4'b0000, 1, 0, 0, 4'b0000, 0);
    cyc("lvl_cmpl2", 4'b0000, 0, 1, 2, 4'b0000, 0);
    // arbitration among sources 1,3,4 with priorities 2,3,3
    cyc("arb_pend", 4'b1101, 0, 0, 0, 4'b1101, 0);
    cyc("arb_id3", 4'b0000, 0, 0, 0, 4'b1101, 3);
    cyc("arb_claim3", 4'b0000, 1, 0, 0, 4'b1001, 0);
    cyc("arb_id4", 4'b0000, 0, 0, 0, 4'b1001, 4);
    cyc("arb_claim4", 4'b0000, 1, 0, 0, 4'b0001, 0);
    cyc("arb_id1", 4'b0000, 0, 0, 0, 4'b0001, 1);
    thr = 2'd2;
    cyc("thr_block", 4'b0000, 0, 0, 0, 4'b0001, 0);
    cyc("thr_cmpl3", 4'b0000, 0, 1, 3, 4'b0001, 0);
    cyc("thr_cmpl4", 4'b0000, 0, 1, 4, 4'b0001, 0);
    thr = 2'd1;
    cyc("thr_release", 4'b0000, 0, 0, 0, 4'b0001, 1);
    cyc("thr_claim1", 4'b0000, 1, 0, 0, 4'b0000, 0);
    cyc("thr_cmpl1", 4'b0000, 0, 1, 1, 4'b0000, 0);
    le = 4'b0001;
`ifdef IRQ_GATEWAY_EDGE_EN
    cyc("edge_pend", 4'b0001, 0, 0, 0, 4'b0001, 0);
    cyc("edge_irq", 4'b0000, 0, 0, 0, 4'b0001, 1);
    cyc("edge_claim", 4'b0000, 1, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("edge_hi", 4'b0001, 0, 0, 0, 4'b0000, 0);
      cyc("edge_lo", 4'b0000, 0, 0, 0, 4'b0000, 0);
    end
    cyc("edge_cmpl", 4'b0000, 0, 1, 1, 4'b0001, 0);
    cyc("edge_redeliver", 4'b0000, 0, 0, 0, 4'b0001, 1);
    cyc("edge_claim2", 4'b0000, 1, 0, 0, 4'b0000, 0);
    cyc("edge_cmpl2", 4'b0000, 0, 1, 1, 4'b0000, 0);
    for (int i = 0; i < 3; i++) cyc("edge_quiet", 4'b0000, 0, 0, 0, 4'b0000, 0);
`else
    cyc("noedge_pulse", 4'b0001, 0, 0, 0, 4'b0001, 0);
    cyc("noedge_irq", 4'b0000, 0, 0, 0, 4'b0001, 1);
    cyc("noedge_claim", 4'b0001, 1, 0, 0, 4'b0000, 0);
    cyc("noedge_insv", 4'b0001, 0, 0, 0, 4'b0000, 0);
    cyc("noedge_cmpl", 4'b0001, 0, 1, 1, 4'b0000, 0);
    cyc("noedge_repend", 4'b0001, 0, 0, 0, 4'b0001, 0);
    cyc("noedge_reirq", 4'b0000, 0, 0, 0, 4'b0001, 1);
    cyc("noedge_claim2", 4'b0000, 1, 0, 0, 4'b0000, 0);
    cyc("noedge_cmpl2", 4'b0000, 0, 1, 1, 4'b0000, 0);
`endif
    // illegal completes: source 2 in service, source 3 pending
    cyc("ill_pend", 4'b0110, 0, 0, 0, 4'b0110, 0);
    cyc("ill_id2", 4'b0000, 0, 0, 0, 4'b0110, 2);
    cyc("ill_claim2", 4'b0000, 1, 0, 0, 4'b0100, 0);
    cyc("ill_id3", 4'b0010, 0, 0, 0, 4'b0100, 3);
    cyc("ill_cmpl0", 4'b0010, 0, 1, 0, 4'b0100, 3);
    cyc("ill_cmpl5", 4'b0010, 0, 1, 5, 4'b0100, 3);
    cyc("ill_cmpl3", 4'b0010, 0, 1, 3, 4'b0100, 3);
    cyc("ok_cmpl2", 4'b0010, 0, 1, 2, 4'b0100, 3);
    cyc("ok_repend2", 4'b0010, 0, 0, 0, 4'b0110, 3);
    cyc("ok_id2", 4'b0000, 0, 0, 0, 4'b0110, 2);
    // build up 3 in-service sources plus a pending one, then reset
    cyc("rs_claim2", 4'b0000, 1, 0, 0, 4'b0100, 0);
    cyc("rs_id3", 4'b0000, 0, 0, 0, 4'b0100, 3);
    cyc("rs_claim3", 4'b0000, 1, 0, 0, 4'b0000, 0);
    cyc("rs_pend1", 4'b0001, 0, 0, 0, 4'b0001, 0);
    cyc("rs_id1", 4'b0000, 0, 0, 0, 4'b0001, 1);
    cyc("rs_claim1", 4'b0000, 1, 0, 0, 4'b0000, 0);
    le = 4'b1111;
    cyc("rs_pend4", 4'b1111, 0, 0, 0, 4'b1000, 0);
    cyc("rs_id4", 4'b0000, 0, 0, 0, 4'b1000, 4);
    rst = 1'b1;
    cyc("rs_reset", 4'b0000, 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc("rs_quiet", 4'b0000, 0, 0, 0, 4'b0000, 0);
    cyc("rs_cmpl_stale", 4'b0000, 0, 1, 1, 4'b0000, 0);
    cyc("rs_after", 4'b0000, 0, 0, 0, 4'b0000, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_gateway.md
# irq_gateway

Interrupt gateway and single-target arbiter downstream of the timer and other peripheral interrupt outputs (e.g. `intr_timer_expired_0_0_o`). It:
- latches level or edge interrupt requests per source;
- selects the highest-priority enabled pending source above a threshold;
- presents the selected source to one hart through a claim/complete handshake.

Each source has an IDLE / PENDING / IN_SERVICE state machine, so a source is never re-delivered while its handler is running.

## Interface
Parameters:
- `NSRC`, 4: number of interrupt sources. Source IDs are 1..NSRC, and ID 0 means "none". `src_i[i]` maps to ID i+1.
- `PRIOW`, 2: priority width in bits.
- `IDW`, `$clog2(NSRC+1)`: ID width (derived; not overridden).

Ports:
- `clk_i`  in  1  clock. This is the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `src_i`  in  NSRC  raw interrupt requests, already synchronous to `clk_i`.
- `le_i`  in  NSRC  per-source mode: 1 = rising edge, 0 = level.
- `ie_i`  in  NSRC  per-source enable.
- `prio_i`  in  NSRC*PRIOW  per-source priority; source i uses bits `[i*PRIOW +: PRIOW]`.
- `threshold_i`  in  PRIOW  delivery threshold.
- `claim_i`  in  1  one-cycle claim strobe from the hart.
- `complete_i`  in  1  one-cycle completion strobe.
- `complete_id_i`  in  IDW  ID being completed.
- `claim_id_o`  out  IDW  registered ID of the best deliverable source, 0 if none.
- `irq_o`  out  1  registered interrupt to the hart; equals `claim_id_o != 0`.
- `pending_o`  out  NSRC  per-source PENDING flag.

## Operation
- Per-source states are IDLE, PENDING and IN_SERVICE.
- Level mode:
  - IDLE with `src_i` = 1 goes to PENDING.
  - PENDING stays set even if `src_i` drops.
- Edge mode:
  - A rising edge is `src_i & ~src_q`, where `src_q` is the registered previous value.
  - IDLE with a rising edge goes to PENDING.
  - A rising edge while PENDING or IN_SERVICE sets `held`, a 1-deep flag. Further edges are lost.
- Eligibility: a source is eligible when PENDING, `ie_i` = 1 and prio > `threshold_i` (unsigned compare). Priority 0 is therefore never delivered.
- Arbitration:
  - Among eligible sources, the highest priority wins.
  - On equal priority, the lowest ID wins.
  - The result is registered into `claim_id_o` and `irq_o`.
- Claim:
  - `claim_i` with `claim_id_o` = k > 0 moves source k from PENDING to IN_SERVICE.
  - The same edge forces `claim_id_o` to 0 and `irq_o` to 0, which blocks a double claim.
  - `claim_i` with `claim_id_o` = 0 has no effect.
- Complete:
  - `complete_i` with `complete_id_i` = k, where source k is IN_SERVICE:
    - edge mode with `held` = 1: go to PENDING and clear `held`;
    - otherwise: go to IDLE.
  - Completing an ID that is 0, out of range, or not IN_SERVICE is ignored.
- Simultaneous claim and complete: both take effect on the same edge. They can never target the same source.
- Simultaneous arrival of a new request and a claim: new requests are evaluated on the next arbitration cycle.
- Clearing `ie_i` of a PENDING source removes it from arbitration but keeps it PENDING.
- Clearing `ie_i` of an IN_SERVICE source has no effect on its state.

## Timing
- Reset, on any `rst_i`-high edge, including mid-operation:
  - all states go to IDLE;
  - `held` = 0 and `src_q` = 0;
  - `claim_id_o` = 0, `irq_o` = 0, `pending_o` = 0.
- Request latency:
  - `src_i` is sampled at edge t, and the source becomes PENDING at t (`pending_o` high after t).
  - `claim_id_o` and `irq_o` are valid after edge t+1. Request-to-`irq_o` latency is 2 cycles.
- Claim sampled at edge t:
  - source IN_SERVICE and `claim_id_o` = 0 after t;
  - re-arbitrated value after t+1.
- Complete sampled at edge t: the state update is visible after t. A re-pend (held edge, or level still high) reaches `irq_o` after t+2.
- Threshold, priority and enable changes take effect on `claim_id_o` one cycle after they are sampled.

## Configuration
- `IRQ_GATEWAY_EDGE_EN`:
  - Defined: per-source edge mode as above, with `src_q` and `held` registers implemented.
  - Undefined: `le_i` is ignored, all sources are level-only, and the `src_q` and `held` logic is not compiled.

## Test plan
- Level request: src 2 has prio 3, threshold 1, `ie_i` all set, and `src_i[1]` rises at cycle 0.
  - `pending_o` = 4'b0010 after cycle 0.
  - `irq_o` = 1 and `claim_id_o` = 2 after cycle 1.
  - Claim: `irq_o` = 0 the next cycle and `pending_o` = 0.
  - Complete with ID 2 while the level is still high: re-pends, and `irq_o` = 1 two cycles later.
- Arbitration: sources 1, 3 and 4 are pending with prio 2, 3, 3.
  - `claim_id_o` = 3.
  - Claim: next ID = 4. Claim again: next ID = 1.
  - Threshold = 2: source 1 is never delivered.
- Edge hold (`IRQ_GATEWAY_EDGE_EN` defined): source 1 is edge-mode and receives 3 edges while IN_SERVICE.
  - Complete: exactly one further delivery of ID 1, then `irq_o` stays 0.
- Edge mode without the macro: source 1 has `le_i` = 1.
  - A one-cycle pulse is still latched as a level request.
  - `src_i` held high after complete re-pends, proving `le_i` is ignored.
- Illegal completes and reset: complete ID 0, ID 5 and a PENDING ID produce no state change.
  - Asserting `rst_i` for one cycle with 3 sources IN_SERVICE gives all outputs 0 the next cycle, and no stale `held` delivery afterwards.
